uart_rx_pio_ctrl: RTL
=====================

UART_RX_PIO_CTRL -- requirements
Module: uart_rx_pio_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes; power of two, range 2..128.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select; read and write are ignored when low.
REQ-006 read  input  1  read strobe, single cycle.
REQ-007 write  input  1  write strobe, single cycle.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data, fixed read latency 1.
REQ-010 rx_data  input  8  received byte from the UART receiver.
REQ-011 rx_valid  input  1  one-cycle strobe; rx_data is valid on that cycle.
REQ-012 irq  output  1  level interrupt to the CPU.

Function
REQ-013 Receive FIFO SHALL be DEPTH x 8 bits, with write pointer, read pointer and a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-014 Push SHALL occur on rx_valid when not full; on rx_valid while full, the byte SHALL be dropped, FIFO unchanged, overflow flag set.
REQ-015 Address 0 DATA read SHALL return head byte in readdata[7:0], bits [31:8]=0, and pop one entry; when empty it SHALL return 0 and perform no pop.
REQ-016 Address 1 STATUS read SHALL return count in [7:0], empty in [8], full in [9], overflow in [10], 0 elsewhere.
REQ-017 Address 1 write with writedata[10]=1 SHALL clear overflow (write-1-to-clear); other bits are ignored.
REQ-018 Address 2 CONTROL write SHALL load irq_en from writedata[0]; writedata[1]=1 SHALL flush the FIFO (pointers and count to 0; overflow unaffected).
REQ-019 Address 2 CONTROL read SHALL return irq_en in [0], 0 elsewhere; flush is not readable.
REQ-020 Address 3 SHALL read 0; writes to it SHALL be ignored.
REQ-021 readdata SHALL update only on the clock edge where chipselect&read is high, reflecting state before that edge, and SHALL hold its value otherwise.
REQ-022 Simultaneous push and pop with FIFO non-empty SHALL both take effect, count unchanged, including when full (no overflow).
REQ-023 Simultaneous push and pop with FIFO empty: read returns 0, push accepted, count becomes 1.
REQ-024 Overflow set and W1C clear on the same cycle: set SHALL win.
REQ-025 Flush and push on the same cycle: flush SHALL win, byte discarded, overflow not set.
REQ-026 irq SHALL equal irq_en & (!empty | overflow), driven from registered state, glitch-free.
REQ-027 Simultaneous read and write on the same cycle SHALL be served: read per REQ-021, write applied.

Reset
REQ-028 On reset_n low, asynchronously: pointers, count, overflow, irq_en and readdata SHALL go to 0; irq SHALL be 0; FIFO storage contents need not be reset.
REQ-029 A push or access in progress when reset asserts SHALL be discarded; after release, the first rx_valid SHALL land at FIFO slot 0.

Verification
REQ-030 Push 0x41,0x42,0x43; read addr1 -> 0x103 clear of empty, i.e. readdata=0x00000003; three addr0 reads -> 0x41,0x42,0x43 one cycle after each read; addr1 -> 0x00000100.
REQ-031 Push DEPTH+1 bytes (8 is default) -> status 0x00000608 (count 8, full, overflow); first drop byte lost; write addr1 0x400 -> status 0x00000208.
REQ-032 Full FIFO, rx_valid and addr0 read on the same cycle -> old head returned, count stays 8, overflow stays 0.
REQ-033 irq_en=1, empty -> irq=0; one push -> irq=1 the next cycle; pop it -> irq=0; set overflow -> irq=1 until W1C.
REQ-034 Push 5 bytes, write addr2 0x3 with rx_valid high on the same cycle -> count 0, empty 1, overflow 0, irq_en 1.
REQ-035 Assert reset_n low mid-stream with 4 bytes queued -> readdata, irq and status 0 immediately; next byte read back from addr0 correctly.

Source files
------------

// File: rtl/uart_rx_pio_ctrl.sv
// Avalon-MM register front end for a UART receiver: buffers received bytes in a
// DEPTH x 8 FIFO and exposes data, status and control words plus a level irq.
module uart_rx_pio_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          irq_en;

  logic          empty;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          pop;
  logic          push;
  logic          flush;
  logic          ovf_set;
  logic          ovf_clr;
  logic [CW-1:0] count_next;
  logic          overflow_next;
  logic          irq_en_next;
  logic [31:0]   rd_word;

  // Bits of writedata that no register decodes.
  logic          wd_unused;
  assign wd_unused = ^{writedata[31:11], writedata[9:2]};

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = chipselect & read;
  assign wr_en = chipselect & write;

  // rx_valid has no back-pressure: a byte arriving while full is lost unless
  // a pop frees a slot on the same edge; a flush on that edge discards it.
  always_comb begin
    pop           = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    ovf_set       = 1'b0;
    ovf_clr       = 1'b0;
    count_next    = count;
    overflow_next = overflow;
    irq_en_next   = irq_en;

    pop     = rd_en && (address == ADDR_DATA) && !empty;
    flush   = wr_en && (address == ADDR_CTRL) && writedata[1];
    push    = rx_valid && (!full || pop) && !flush;
    ovf_set = rx_valid && full && !pop && !flush;
    ovf_clr = wr_en && (address == ADDR_STATUS) && writedata[10];

    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end

    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end

    if (wr_en && (address == ADDR_CTRL)) begin
      irq_en_next = writedata[0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:   rd_word = empty ? 32'd0 : {24'd0, mem[rd_ptr]};
      ADDR_STATUS: rd_word = {21'd0, overflow, full, empty, 8'(count)};
      ADDR_CTRL:   rd_word = {31'd0, irq_en};
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      overflow <= overflow_next;
      irq_en   <= irq_en_next;
      if (rd_en) readdata <= rd_word;
      // Registered from next-state values so irq moves on the same edge as the state.
      irq <= irq_en_next & ((count_next != '0) | overflow_next);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

endmodule
